ifetch_pipe: RTL
================

# ifetch_pipe

Parametrised instruction-fetch stage. It owns the fetch PC and drives a synchronous instruction ROM with 1-cycle read latency. Fetched instructions are buffered in a 2-entry queue and presented to decode through a valid/ready handshake. It resolves branch/jump redirects (beq, bne, jal, jalr) from execute, and halts with a sticky fault when a redirect target is misaligned.

## Interface
- XLEN, 32, PC and instruction width
- ADDR_W, 14, ROM word-address width; imem_addr = fpc[ADDR_W+1:2]
- RESET_PC, 0, fetch PC after reset; must be 4-aligned
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- redir_op  in  3  000 none, 001 beq, 010 bne, 011 jal, 100 jalr; other codes treated as none
- zero  in  1  ALU zero flag for beq/bne
- br_pc  in  XLEN  PC of the branch/jump instruction
- imm32  in  XLEN  sign-extended offset
- rs1  in  XLEN  jalr base register
- imem_en  out  1  ROM read enable (combinational from registered state and inputs)
- imem_addr  out  ADDR_W  ROM word address
- imem_rdata  in  XLEN  ROM data, valid the cycle after imem_en
- out_valid  out  1  out_inst/out_pc valid
- out_ready  in  1  decode accepts
- out_inst  out  XLEN  instruction
- out_pc  out  XLEN  its byte PC
- out_pc4  out  XLEN  out_pc+4 (link value)
- fault  out  1  sticky misaligned-target fault
- fault_pc  out  XLEN  offending target

## Operation
- State register: RUN or HALT. Reset puts the block in RUN.
- Redirect taken (`take`) when any of these hold:
  - redir_op=jal;
  - redir_op=jalr;
  - redir_op=beq and zero=1;
  - redir_op=bne and zero=0.
- Not-taken branches have no effect.
- Target:
  - beq/bne/jal: br_pc+imm32;
  - jalr: (rs1+imm32) & ~1.
  - All sums are modulo 2^XLEN.
- Misaligned target: target[1]=1 (after the jalr bit-0 clear). Result:
  - state goes to HALT; fault=1; fault_pc=target;
  - queue and in-flight fetch are flushed;
  - no further imem_en until reset.
- In HALT, all redir_op values are ignored.
- Issue rule, in RUN with take=0:
  - imem_en=1 when occ + inflight − pop < 2, where occ = queue entries (0..2), inflight = fetch issued last cycle, pop = out_valid & out_ready.
  - On issue: record inflight with tag pc=fpc; fpc <= fpc+4. Wrap-around is modulo 2^XLEN; imem_addr wraps modulo 2^ADDR_W.
- Response: a tagged inflight writes {imem_rdata, tag} into the queue tail.
- Queue is FIFO; the head drives out_*. Push and pop may occur in the same cycle.
- Redirect cycle (take=1, aligned target):
  - imem_en=0;
  - queue cleared; inflight response discarded;
  - fpc <= target.
  - A pop in the same cycle still counts as delivered.
- Redirect has priority over issue and response in the same cycle.
- Reset mid-operation clears everything immediately (asynchronous).
- Reset values: fpc=RESET_PC, occ=0, inflight=0, out_valid=0, fault=0, fault_pc=0, state RUN. imem_en=0 while rst=0.
- out_inst/out_pc/out_pc4 are don't-care while out_valid=0.

## Timing
- Cycle numbering: C0 is the first cycle after rst deasserts.
- Startup:
  - C0: imem_en=1 at RESET_PC.
  - C1: out_valid=1, out_pc=RESET_PC.
  - Thereafter one instruction per cycle while out_ready=1.
- Redirect at cycle R:
  - R+1: imem_en at target.
  - R+2: out_valid=1 with out_pc=target.
  - Redirect penalty is 2 bubbles.
- Back-pressure:
  - out_ready=0 while the queue is full: imem_en=0 and out_* held stable.
  - out_ready=1 resumes without loss or duplication.
- Fault at cycle R: fault=1 and out_valid=0 from R+1 onward.
- Handshake: out_valid never drops without a pop or a redirect. out_* is stable while out_valid=1 and out_ready=0.

## Test plan
- Reset with RESET_PC=0, ROM word k = k, out_ready=1 -> out_pc 0,4,8,... on consecutive cycles from C1; out_inst=k; out_pc4=out_pc+4.
- out_ready pattern 1,0,0,0,1,1 -> no lost or duplicated PCs; imem_en=0 while the queue is full; out_* stable while stalled.
- beq br_pc=0x10, imm32=0x20, zero=1 -> out_pc=0x30 two cycles later, stale PCs dropped. Same with zero=0 -> sequence unchanged. bne with zero=0 -> taken.
- jalr rs1=0x101, imm32=0x3 -> target 0x104. Also jal with imm32=−8 from br_pc=0x8 -> 0x0.
- jal br_pc=0x0, imm32=0x6 -> fault=1, fault_pc=0x6, no imem_en afterwards; a later redirect is ignored; rst low clears fault and restarts at RESET_PC.
- ADDR_W=4, sequential run past PC 0x3C -> imem_addr wraps 15->0 while out_pc continues to 0x40. Also: rst asserted mid-stall -> out_valid=0 immediately, restart from RESET_PC.

Source files
------------

// File: rtl/ifetch_pipe.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle synchronous ROM,
// buffers responses in a 2-entry queue for decode and resolves execute redirects.
module ifetch_pipe #(
    parameter int               XLEN     = 32,
    parameter int               ADDR_W   = 14,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        redir_op,
    input  logic              zero,
    input  logic [XLEN-1:0]   br_pc,
    input  logic [XLEN-1:0]   imm32,
    input  logic [XLEN-1:0]   rs1,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_pc4,
    output logic              fault,
    output logic [XLEN-1:0]   fault_pc
);

    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_JALR = 3'b100;

    typedef enum logic {RUN, HALT} state_t;

    state_t          state;
    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] q_inst [2];
    logic [XLEN-1:0] q_pc   [2];
    logic [1:0]      occ;
    logic            infl;
    logic [XLEN-1:0] infl_pc;

    logic            is_run;
    logic            take;
    logic [XLEN-1:0] target;
    logic            misalign;
    logic            pop;
    logic            head_pop;
    logic            push;
    logic [1:0]      occ_pop;
    logic [2:0]      level;

    assign is_run = (state == RUN);

    always_comb begin
        take   = 1'b0;
        target = br_pc + imm32;
        case (redir_op)
            OP_BEQ:  take = zero;
            OP_BNE:  take = ~zero;
            OP_JAL:  take = 1'b1;
            OP_JALR: begin
                take   = 1'b1;
                target = (rs1 + imm32) & ~XLEN'(1);
            end
            default: take = 1'b0;
        endcase
        take = take & is_run;
    end

    assign misalign = target[1];

    // With the queue empty the arriving ROM word is presented directly, which
    // gives the one-cycle fetch-to-decode latency.
    assign out_valid = is_run & ((occ != 2'd0) | infl);
    assign out_inst  = (occ != 2'd0) ? q_inst[0] : imem_rdata;
    assign out_pc    = (occ != 2'd0) ? q_pc[0]   : infl_pc;
    assign out_pc4   = out_pc + XLEN'(4);

    assign pop      = out_valid & out_ready;
    assign head_pop = pop & (occ != 2'd0);
    assign push     = infl & ~(pop & (occ == 2'd0));
    assign occ_pop  = occ - {1'b0, head_pop};

    // In-flight fetches count against queue capacity so a response always has a slot.
    assign level     = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};
    assign imem_en   = rst & is_run & ~take & (level < 3'd2);
    assign imem_addr = fpc[ADDR_W+1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            fpc       <= RESET_PC;
            occ       <= 2'd0;
            infl      <= 1'b0;
            infl_pc   <= '0;
            fault     <= 1'b0;
            fault_pc  <= '0;
            q_inst[0] <= '0;
            q_inst[1] <= '0;
            q_pc[0]   <= '0;
            q_pc[1]   <= '0;
        end else if (take) begin
            occ  <= 2'd0;
            infl <= 1'b0;
            if (misalign) begin
                state    <= HALT;
                fault    <= 1'b1;
                fault_pc <= target;
            end else begin
                fpc <= target;
            end
        end else begin
            infl <= imem_en;
            if (imem_en) begin
                infl_pc <= fpc;
                fpc     <= fpc + XLEN'(4);
            end
            if (head_pop) begin
                q_inst[0] <= q_inst[1];
                q_pc[0]   <= q_pc[1];
            end
            if (push) begin
                q_inst[occ_pop[0]] <= imem_rdata;
                q_pc[occ_pop[0]]   <= infl_pc;
            end
            occ <= occ_pop + {1'b0, push};
        end
    end

endmodule
